// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA timing generator (640x480@60 defaults).
package vga_timing_pkg;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned MAX_TOTAL = 1 << CNT_W;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam logic H_SYNC_POL_DEF = 1'b0;
  localparam logic V_SYNC_POL_DEF = 1'b0;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and next-count decodes.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF,
  parameter logic        POL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             wrap_en,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             active_next_c,
  output logic             zero_next_c,
  output logic             wrap_c
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned XW    = CNT_W + 1;

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [XW-1:0]    ACT_END  = XW'(ACTIVE);
  localparam logic [XW-1:0]    SYNC_BEG = XW'(ACTIVE + FP);
  localparam logic [XW-1:0]    SYNC_END = XW'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] count_next_c;

  function automatic logic sync_level(input logic [CNT_W-1:0] c);
    logic [XW-1:0] cx;
    cx = {1'b0, c};
    return ((cx >= SYNC_BEG) && (cx < SYNC_END)) ? POL : ~POL;
  endfunction

  // Next-count decode; flags are registered from it so they line up with count.
  always_comb begin
    wrap_c       = advance & wrap_en & (count == LAST);
    count_next_c = count;
    if (advance) begin
      count_next_c = wrap_c ? '0 : count + CNT_W'(1);
    end
    active_next_c = ({1'b0, count_next_c} < ACT_END);
    zero_next_c   = (count_next_c == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LAST;
      sync  <= sync_level(LAST);
    end else begin
      count <= count_next_c;
      sync  <= sync_level(count_next_c);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel position, blanking flag, sync pins and start strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter logic        H_SYNC_POL = H_SYNC_POL_DEF,
  parameter logic        V_SYNC_POL = V_SYNC_POL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  output logic [CNT_W-1:0] x,
  output logic [Y_W-1:0]   y,
  output logic             frame_active,
  output logic             h_sync,
  output logic             v_sync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic [CNT_W-1:0] v_count;
  logic             h_active_next;
  logic             v_active_next;
  logic             h_zero_next;
  logic             v_zero_next;
  logic             h_wrap;
  logic             v_wrap_unused;
  logic             unused_v_msb;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL)
  ) u_h_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .advance      (clk_en),
    .wrap_en      (1'b1),
    .count        (x),
    .sync         (h_sync),
    .active_next_c(h_active_next),
    .zero_next_c  (h_zero_next),
    .wrap_c       (h_wrap)
  );

  // Vertical axis only moves on the horizontal wrap, and may wrap only then.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL)
  ) u_v_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .advance      (h_wrap),
    .wrap_en      (h_wrap),
    .count        (v_count),
    .sync         (v_sync),
    .active_next_c(v_active_next),
    .zero_next_c  (v_zero_next),
    .wrap_c       (v_wrap_unused)
  );

  // y deliberately aliases during tall blanking; consumers gate with frame_active.
  assign y            = v_count[Y_W-1:0];
  assign unused_v_msb = v_count[CNT_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_active <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_active <= h_active_next & v_active_next;
      line_start   <= h_zero_next;
      frame_start  <= h_zero_next & v_zero_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default 640x480 instance plus a narrow-line instance for frame-level checks.
module tb_vga_timing_gen;

  localparam int HT0 = 800;
  localparam int VT0 = 525;
  localparam int HA1 = 4;
  localparam int HF1 = 1;
  localparam int HS1 = 2;
  localparam int HB1 = 1;
  localparam int HT1 = HA1 + HF1 + HS1 + HB1;
  localparam int VT1 = 525;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;

  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic fa0, hs0, vs0, ls0, fs0;
  logic fa1, hs1, vs1, ls1, fs1;
  logic [23:0] obs0, obs1;

  int errors = 0;
  int checks = 0;
  int mh0, mv0, mh1, mv1;

  always #5 clk = ~clk;

  vga_timing_gen u_dut0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .x(x0), .y(y0), .frame_active(fa0),
    .h_sync(hs0), .v_sync(vs0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(.H_ACTIVE(HA1), .H_FP(HF1), .H_SYNC(HS1), .H_BP(HB1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .x(x1), .y(y1), .frame_active(fa1),
    .h_sync(hs1), .v_sync(vs1), .line_start(ls1), .frame_start(fs1)
  );

  assign obs0 = {x0, y0, fa0, hs0, vs0, ls0, fs0};
  assign obs1 = {x1, y1, fa1, hs1, vs1, ls1, fs1};

  // Reference outputs from a raster position; active-low syncs.
  function automatic logic [23:0] model(input int h, input int v, input int ha, input int hf,
                                        input int hs);
    logic [9:0] ex;
    logic [8:0] ey;
    logic efa, ehs, evs, els, efs;
    ex  = 10'(h);
    ey  = 9'(v % 512);
    efa = (h < ha) && (v < 480);
    ehs = !((h >= ha + hf) && (h < ha + hf + hs));
    evs = !((v >= 490) && (v < 492));
    els = (h == 0);
    efs = (h == 0) && (v == 0);
    return {ex, ey, efa, ehs, evs, els, efs};
  endfunction

  task automatic model_reset();
    mh0 = HT0 - 1; mv0 = VT0 - 1;
    mh1 = HT1 - 1; mv1 = VT1 - 1;
  endtask

  task automatic tick(input logic en);
    clk_en = en;
    @(posedge clk);
    #1;
    if (en) begin
      mh0 = (mh0 + 1) % HT0;
      if (mh0 == 0) mv0 = (mv0 + 1) % VT0;
      mh1 = (mh1 + 1) % HT1;
      if (mh1 == 0) mv1 = (mv1 + 1) % VT1;
    end
  endtask

  task automatic test_reset();
    logic [23:0] exp0, exp1, exp_first;
    rst_n  = 1'b0;
    clk_en = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    exp0 = {10'd799, 9'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp1 = {10'd7, 9'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs0 !== exp0) begin
      errors++; $display("FAIL reset_default: got %h expected %h", obs0, exp0);
    end
    checks++;
    if (obs1 !== exp1) begin
      errors++; $display("FAIL reset_narrow: got %h expected %h", obs1, exp1);
    end
    rst_n = 1'b1;
    tick(1'b1);
    exp_first = {10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs0 !== exp_first) begin
      errors++; $display("FAIL first_edge_default: got %h expected %h", obs0, exp_first);
    end
    checks++;
    if (obs1 !== exp_first) begin
      errors++; $display("FAIL first_edge_narrow: got %h expected %h", obs1, exp_first);
    end
  endtask

  task automatic test_horizontal();
    int hs_low = 0;
    int act = 0;
    for (int i = 0; i < HT0; i++) begin
      tick(1'b1);
      if (!hs0) hs_low++;
      if (fa0) act++;
      checks++;
      if (obs0 !== model(mh0, mv0, 640, 16, 96)) begin
        errors++;
        $display("FAIL line_default h=%0d v=%0d: got %h expected %h", mh0, mv0, obs0,
                 model(mh0, mv0, 640, 16, 96));
      end
    end
    checks++;
    if (hs_low !== 96) begin
      errors++; $display("FAIL hsync_width: got %0d expected 96", hs_low);
    end
    checks++;
    if (act !== 640) begin
      errors++; $display("FAIL active_width: got %0d expected 640", act);
    end
    checks++;
    if ({x0, y0} !== {10'd0, 9'd1}) begin
      errors++; $display("FAIL line_wrap: got x=%0d y=%0d expected x=0 y=1", x0, y0);
    end
  endtask

  task automatic test_frame();
    int vs_low = 0;
    int fs_cnt = 0;
    int blank_active = 0;
    for (int i = 0; i < HT1 * VT1; i++) begin
      tick(1'b1);
      if (!vs1) vs_low++;
      if (fs1) fs_cnt++;
      if (fa1 && mv1 >= 480) blank_active++;
      checks++;
      if (obs1 !== model(mh1, mv1, HA1, HF1, HS1)) begin
        errors++;
        $display("FAIL frame_narrow h=%0d v=%0d: got %h expected %h", mh1, mv1, obs1,
                 model(mh1, mv1, HA1, HF1, HS1));
      end
      checks++;
      if (obs0 !== model(mh0, mv0, 640, 16, 96)) begin
        errors++;
        $display("FAIL frame_default h=%0d v=%0d: got %h expected %h", mh0, mv0, obs0,
                 model(mh0, mv0, 640, 16, 96));
      end
      if (mv1 == 512 && mh1 == 0) begin
        checks++;
        if ({y1, fa1} !== {9'd0, 1'b0}) begin
          errors++; $display("FAIL y_alias_512: got y=%0d fa=%b expected y=0 fa=0", y1, fa1);
        end
      end
      if (mv1 == 0 && mh1 == 0) begin
        checks++;
        if ({x1, y1, fs1} !== {10'd0, 9'd0, 1'b1}) begin
          errors++; $display("FAIL frame_wrap: got x=%0d y=%0d fs=%b expected 0 0 1", x1, y1, fs1);
        end
      end
    end
    checks++;
    if (vs_low !== 2 * HT1) begin
      errors++; $display("FAIL vsync_width: got %0d expected %0d", vs_low, 2 * HT1);
    end
    checks++;
    if (fs_cnt !== 1) begin
      errors++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
    end
    checks++;
    if (blank_active !== 0) begin
      errors++; $display("FAIL active_in_vblank: got %0d expected 0", blank_active);
    end
  endtask

  task automatic test_clk_en();
    int ls_cnt = 0;
    logic en;
    for (int i = 0; i < 64; i++) begin
      tick(1'(i % 2 == 0));
      if (ls1) ls_cnt++;
      checks++;
      if (obs1 !== model(mh1, mv1, HA1, HF1, HS1)) begin
        errors++;
        $display("FAIL clken_alt h=%0d v=%0d: got %h expected %h", mh1, mv1, obs1,
                 model(mh1, mv1, HA1, HF1, HS1));
      end
    end
    checks++;
    if (ls_cnt !== 8) begin
      errors++; $display("FAIL line_start_stretch: got %0d expected 8", ls_cnt);
    end
    for (int i = 0; i < 200; i++) begin
      en = 1'($urandom_range(0, 1));
      tick(en);
      checks++;
      if (obs0 !== model(mh0, mv0, 640, 16, 96)) begin
        errors++;
        $display("FAIL clken_rand_default h=%0d v=%0d: got %h expected %h", mh0, mv0, obs0,
                 model(mh0, mv0, 640, 16, 96));
      end
      checks++;
      if (obs1 !== model(mh1, mv1, HA1, HF1, HS1)) begin
        errors++;
        $display("FAIL clken_rand_narrow h=%0d v=%0d: got %h expected %h", mh1, mv1, obs1,
                 model(mh1, mv1, HA1, HF1, HS1));
      end
    end
  endtask

  task automatic test_async_reset();
    int budget = 0;
    logic [23:0] exp0, exp1;
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    while (!(mh1 == 5 && mv1 == 491) && budget < 10000) begin
      tick(1'b1);
      budget++;
      checks++;
      if (obs1 !== model(mh1, mv1, HA1, HF1, HS1)) begin
        errors++;
        $display("FAIL pre_reset_run h=%0d v=%0d: got %h expected %h", mh1, mv1, obs1,
                 model(mh1, mv1, HA1, HF1, HS1));
      end
    end
    checks++;
    if (budget >= 10000) begin
      errors++; $display("FAIL reach_sync_point: got budget %0d expected < 10000", budget);
    end
    checks++;
    if ({hs1, vs1} !== 2'b00) begin
      errors++; $display("FAIL both_sync_asserted: got %b expected 00", {hs1, vs1});
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp0 = {10'd799, 9'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp1 = {10'd7, 9'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs1 !== exp1) begin
      errors++; $display("FAIL async_reset_narrow: got %h expected %h", obs1, exp1);
    end
    checks++;
    if (obs0 !== exp0) begin
      errors++; $display("FAIL async_reset_default: got %h expected %h", obs0, exp0);
    end
    model_reset();
    rst_n = 1'b1;
    tick(1'b1);
    checks++;
    if (obs1 !== model(mh1, mv1, HA1, HF1, HS1)) begin
      errors++;
      $display("FAIL post_reset_edge: got %h expected %h", obs1, model(mh1, mv1, HA1, HF1, HS1));
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_frame();
    test_clk_en();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
